// File: rtl/wb_arbiter.sv
// wb_arbiter: two small request FIFOs (EXE path = req0, MEM path = req1)
// share one registered register-file write port with round-robin arbitration.
//
// Handshake: a request is taken at a posedge where valid && ready are both 1.
// ready reflects only current occupancy (FIFO not full), never a same-cycle
// pop, so a full FIFO has no pass-through. A requester holds dest/data stable
// while valid && !ready.
module wb_arbiter #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   input  logic [3:0]  req0_dest,
   input  logic [31:0] req0_data,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [3:0]  req1_dest,
   input  logic [31:0] req1_data,
   output logic        req1_ready,
   output logic        WriteBackEn,
   output logic [3:0]  Dest_WB,
   output logic [31:0] Result_WB,
   output logic [14:0] pending
);

   localparam int          PW       = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
   localparam logic [PW:0] ONE_CNT  = (PW+1)'(1);
   localparam logic [PW-1:0] ONE_PTR = PW'(1);

   // FIFO storage and bookkeeping, index [k] = requester k
   logic [3:0]       r_dest [2][DEPTH];
   logic [31:0]      r_data [2][DEPTH];
   logic [DEPTH-1:0] r_vld  [2];
   logic [PW-1:0]    r_wptr [2];
   logic [PW-1:0]    r_rptr [2];
   logic [PW:0]      r_cnt  [2];

   // 1 when requester 1 was popped most recently; reset value lets req0 win first
   logic             r_last1;

   // Output register
   logic             r_wbe;
   logic [3:0]       r_wb_dest;
   logic [31:0]      r_wb_data;

   logic [1:0]       w_valid;
   logic [1:0]       w_full;
   logic [1:0]       w_ne;
   logic [1:0]       w_acc;
   logic [1:0]       w_pop;
   logic [3:0]       w_in_dest [2];
   logic [31:0]      w_in_data [2];
   logic [DEPTH-1:0] w_set [2];
   logic [DEPTH-1:0] w_clr [2];
   logic             w_sel;
   logic [3:0]       w_head_dest;
   logic [31:0]      w_head_data;
   logic [14:0]      w_pend;

   assign w_valid      = {req1_valid, req0_valid};
   assign w_in_dest[0] = req0_dest;
   assign w_in_dest[1] = req1_dest;
   assign w_in_data[0] = req0_data;
   assign w_in_data[1] = req1_data;

   // Occupancy status and accept decision per FIFO
   always_comb begin
      for (int k = 0; k < 2; k++) begin
         w_full[k] = (r_cnt[k] == FULL_CNT);
         w_ne[k]   = (r_cnt[k] != '0);
         w_acc[k]  = w_valid[k] & ~w_full[k];
      end
   end

   // Readies read 1 while reset is held so requesters never see a stale full
   assign req0_ready = rst | ~w_full[0];
   assign req1_ready = rst | ~w_full[1];

   // Round-robin: a lone non-empty FIFO always wins; on contention the one
   // not popped last wins
   assign w_pop[0] = w_ne[0] & (~w_ne[1] | r_last1);
   assign w_pop[1] = w_ne[1] & (~w_ne[0] | ~r_last1);

   assign w_sel       = w_pop[1];
   assign w_head_dest = r_dest[w_sel][r_rptr[w_sel]];
   assign w_head_data = r_data[w_sel][r_rptr[w_sel]];

   // Per-slot valid set/clear masks for this cycle's accept and pop
   always_comb begin
      for (int k = 0; k < 2; k++) begin
         w_set[k] = '0;
         w_clr[k] = '0;
         if (w_acc[k]) w_set[k][r_wptr[k]] = 1'b1;
         if (w_pop[k]) w_clr[k][r_rptr[k]] = 1'b1;
      end
   end

   // FIFO pointers, occupancy and slot valids; reset empties both FIFOs
   always_ff @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            r_wptr[k] <= '0;
            r_rptr[k] <= '0;
            r_cnt[k]  <= '0;
            r_vld[k]  <= '0;
         end else begin
            if (w_acc[k]) r_wptr[k] <= r_wptr[k] + ONE_PTR;
            if (w_pop[k]) r_rptr[k] <= r_rptr[k] + ONE_PTR;
            if (w_acc[k] && !w_pop[k])
               r_cnt[k] <= r_cnt[k] + ONE_CNT;
            else if (!w_acc[k] && w_pop[k])
               r_cnt[k] <= r_cnt[k] - ONE_CNT;
            r_vld[k] <= (r_vld[k] | w_set[k]) & ~w_clr[k];
         end
      end
   end

   // FIFO payload storage; slot valids make a reset of the payload unnecessary
   always_ff @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (w_acc[k]) begin
            r_dest[k][r_wptr[k]] <= w_in_dest[k];
            r_data[k][r_wptr[k]] <= w_in_data[k];
         end
      end
   end

   // Round-robin pointer moves only when something is actually popped
   always_ff @(posedge clk) begin
      if (rst)           r_last1 <= 1'b1;
      else if (w_pop[0]) r_last1 <= 1'b0;
      else if (w_pop[1]) r_last1 <= 1'b1;
   end

   // Output register: load the popped head; dest 15 drains without a write
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wbe     <= 1'b0;
         r_wb_dest <= '0;
         r_wb_data <= '0;
      end else if (|w_pop) begin
         r_wbe     <= (w_head_dest != 4'hF);
         r_wb_dest <= w_head_dest;
         r_wb_data <= w_head_data;
      end else begin
         r_wbe     <= 1'b0;
      end
   end

   assign WriteBackEn = r_wbe;
   assign Dest_WB     = r_wb_dest;
   assign Result_WB   = r_wb_data;

   // Scoreboard bits: queued entries plus the write currently on the port
   always_comb begin
      w_pend = '0;
      for (int j = 0; j < 15; j++) begin
         for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (r_vld[k][i] && (r_dest[k][i] == 4'(j))) w_pend[j] = 1'b1;
            end
         end
         if (r_wbe && (r_wb_dest == 4'(j))) w_pend[j] = 1'b1;
      end
   end

   assign pending = rst ? 15'h0 : w_pend;

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, giving the entries per requester FIFO (legal values 2 or 4).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its posedge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset sampled at posedge clk.
REQ-004 The block SHALL have port req0_valid, input, 1 bit: EXE-path write request valid.
REQ-005 The block SHALL have port req0_dest, input, 4 bits: EXE-path destination register index.
REQ-006 The block SHALL have port req0_data, input, 32 bits: EXE-path write data.
REQ-007 The block SHALL have port req0_ready, output, 1 bit: EXE-path FIFO can accept an entry.
REQ-008 The block SHALL have ports req1_valid, req1_dest and req1_data (inputs) and req1_ready (output), with the same widths and meanings as the req0 ports, for the MEM path.
REQ-009 The block SHALL have port WriteBackEn, output, 1 bit: register-file write enable.
REQ-010 The block SHALL have port Dest_WB, output, 4 bits: register-file write index.
REQ-011 The block SHALL have port Result_WB, output, 32 bits: register-file write data.
REQ-012 The block SHALL have port pending, output, 15 bits: bit i is set while any write to register i is queued or in flight.

Function
REQ-013 Request k SHALL be accepted at a posedge where reqk_valid and reqk_ready are both 1, appending {dest, data} to FIFO k.
REQ-014 reqk_ready SHALL equal "FIFO k not full" and SHALL NOT depend on a pop in the same cycle, giving no pass-through when full.
REQ-015 At each posedge, at most one FIFO head SHALL be popped into the output register {WriteBackEn, Dest_WB, Result_WB}.
REQ-016 Arbitration SHALL follow these rules:
- Only FIFO k non-empty: pop FIFO k.
- Both non-empty: pop the FIFO not popped most recently (round-robin).
- Neither non-empty: pop nothing.
REQ-017 The round-robin pointer SHALL update only on a pop of a non-empty FIFO.
REQ-018 On a pop, the output register SHALL load Dest_WB = head dest, Result_WB = head data, and WriteBackEn = 1 if dest < 15.
REQ-019 A popped entry with dest = 15 SHALL set WriteBackEn = 0; Dest_WB and Result_WB still load, and the slot is freed.
REQ-020 With no pop, WriteBackEn SHALL be 0 in the following cycle, and Dest_WB and Result_WB SHALL hold their values.
REQ-021 Latency SHALL be as follows:
- An entry accepted at posedge N into an empty FIFO that wins arbitration pops at posedge N+1.
- WriteBackEn is then high for the cycle N+1 to N+2, so the register file's negedge write lands within that cycle.
REQ-022 Within one requester, writes SHALL leave in acceptance order; no ordering is guaranteed across requesters.
REQ-023 An accept and a pop on the same FIFO in the same cycle SHALL both take effect; occupancy is unchanged.
REQ-024 pending SHALL be combinational: the OR over all valid FIFO entries with dest < 15, plus the output register when WriteBackEn = 1.
REQ-025 Occupancy counters and pointers SHALL wrap modulo DEPTH with no overflow or underflow.

Reset
REQ-026 When rst = 1 at posedge, the block SHALL load the following reset state; this takes priority over any accept or pop in that cycle:
- Both FIFOs empty.
- WriteBackEn = 0, Dest_WB = 0, Result_WB = 0.
- Round-robin pointer set so req0 wins the first contention.
REQ-027 During reset and in the first cycle after it, req0_ready and req1_ready SHALL read 1, and pending SHALL read 0.
REQ-028 A reset asserted mid-operation SHALL discard all queued entries without issuing their writes.

Verification
REQ-029 The bench SHALL cover a single write: req0 {dest 3, data 0xA5A5A5A5} accepted at edge N -> WriteBackEn=1, Dest_WB=3, Result_WB=0xA5A5A5A5 for cycle N+1; pending[3] set from after edge N until after edge N+2.
REQ-030 The bench SHALL cover contention: both requesters accept at the same edge (req0 dest 1, req1 dest 2), repeated 3 times -> writes issue in order 1,2,1,2,1,2 on consecutive cycles.
REQ-031 The bench SHALL cover full/backpressure: req1 valid for 5 cycles, DEPTH=2, req0 idle -> req1_ready never deasserts once steady-state pop starts; with req0 also streaming, each ready drops to 0 whenever its FIFO holds 2 entries.
REQ-032 The bench SHALL cover dest 15: req0 {dest 15} -> pops after one cycle, WriteBackEn=0, pending stays 0.
REQ-033 The bench SHALL cover reset mid-stream: both FIFOs full, then rst for 1 cycle -> no further WriteBackEn pulses, readies=1, pending=0, outputs 0.
REQ-034 The bench SHALL cover ordering: req0 writes dest 5 with values 1,2 back-to-back -> register 5 receives 1 then 2.
